// File: rtl/cai_prescaler_pkg.sv
// Shared encodings for the CAI prescaler: FSM states and run modes.
package cai_prescaler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/cai_prescaler_if.sv
// Control/status bundle between a run controller and the CAI prescaler.
interface cai_prescaler_if #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst;
    logic               stop_on_cao;
    logic               cao_in;
    logic               cai;
    logic               busy;
    logic               done;
    logic               ovf;

    modport master (
        output start, stop, mode, div, burst, stop_on_cao, cao_in,
        input  cai, busy, done, ovf
    );

    modport slave (
        input  start, stop, mode, div, burst, stop_on_cao, cao_in,
        output cai, busy, done, ovf
    );
endinterface

// File: rtl/cai_prescaler_div_cnt.sv
// Prescale counter: counts 0..P-1 and wraps, P = max(div, 1); term flags the last count.
module cai_div_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         term
);
    logic [W-1:0] pc;
    logic [W-1:0] p_m1;

    // A divisor of zero behaves as one, so the terminal count is 0 in both cases.
    assign p_m1 = (div == '0) ? '0 : div - W'(1);
    assign term = (pc == p_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr || term) begin
            pc <= '0;
        end else begin
            pc <= pc + W'(1);
        end
    end
endmodule

// File: rtl/cai_prescaler.sv
// Count-enable generator for a cascaded counter chain: periodic CAI pulses, free-run or burst.
//   state   | meaning
//   IDLE    | waiting for START; CAI low, DONE may pulse after a run ends
//   RUN     | prescaler counting; CAI pulses every P clocks
module cai_prescaler
    import cai_prescaler_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 8
) (
    input logic            CLK,
    input logic            CDN,
    cai_prescaler_if.slave bus
);
    state_t             state;
    state_t             state_nx;
    logic [DIV_W-1:0]   divl;
    logic [BURST_W-1:0] bc;
    logic               model;
    logic               socl;
    logic               done;
    logic               done_nx;
    logic               ovf;
    logic               accept;
    logic               term;
    logic               cai;
    logic               pc_clr;

    assign cai = (state == ST_RUN) && term;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    accept = 1'b1;
                    // An empty burst finishes immediately without ever entering RUN.
                    if (bus.mode == MODE_BURST && bus.burst == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop
                    || (cai && bus.cao_in && socl)
                    || (cai && model == MODE_BURST && bc == BURST_W'(1))) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign pc_clr = !(state == ST_RUN && state_nx == ST_RUN);

    cai_div_cnt #(.W(DIV_W)) u_div_cnt (
        .clk   (CLK),
        .rst_n (CDN),
        .clr   (pc_clr),
        .div   (divl),
        .term  (term)
    );

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            ovf   <= 1'b0;
            divl  <= '0;
            bc    <= '0;
            model <= MODE_FREE;
            socl  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (accept) begin
                divl  <= bus.div;
                bc    <= bus.burst;
                model <= bus.mode;
                socl  <= bus.stop_on_cao;
                ovf   <= 1'b0;
            end else if (state == ST_RUN) begin
                if (cai && model == MODE_BURST) begin
                    bc <= bc - BURST_W'(1);
                end
                if (cai && bus.cao_in && !socl) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.cai  = cai;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = done;
    assign bus.ovf  = ovf;
endmodule

// File: tb/tb_cai_prescaler.sv
// Self-checking bench for cai_prescaler: directed scenarios plus randomized runs against a cycle model.
module tb_cai_prescaler;

    logic clk;
    logic cdn;
    int   checks;
    int   failures;
    bit   cmp_en;

    cai_prescaler_if #(.DIV_W(8), .BURST_W(8)) bus ();

    cai_prescaler #(.DIV_W(8), .BURST_W(8)) dut (
        .CLK (clk),
        .CDN (cdn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run flag, cycles elapsed in the run, pulses left in the burst.
    bit m_run, m_mode, m_soc, m_ovf, m_done;
    int m_k, m_p, m_left;
    wire exp_cai = m_run && ((m_k % m_p) == 0);

    always @(posedge clk or negedge cdn) begin : model
        bit c_now;
        bit fin;
        if (!cdn) begin
            m_run  <= 1'b0;
            m_mode <= 1'b0;
            m_soc  <= 1'b0;
            m_ovf  <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
            m_p    <= 1;
            m_left <= 0;
        end else begin
            c_now = exp_cai;
            m_done <= 1'b0;
            if (!m_run) begin
                if (bus.start && !bus.stop) begin
                    m_ovf  <= 1'b0;
                    m_p    <= (bus.div == 0) ? 1 : int'(bus.div);
                    m_mode <= bus.mode;
                    m_soc  <= bus.stop_on_cao;
                    m_left <= int'(bus.burst);
                    if (bus.mode && bus.burst == 0) begin
                        m_done <= 1'b1;
                    end else begin
                        m_run <= 1'b1;
                        m_k   <= 1;
                    end
                end
            end else begin
                fin = bus.stop || (c_now && bus.cao_in && m_soc)
                      || (c_now && m_mode && m_left == 1);
                if (c_now && m_mode) m_left <= m_left - 1;
                if (c_now && bus.cao_in && !m_soc) m_ovf <= 1'b1;
                if (fin) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && cdn) begin
            check("cmp_cai",  64'(bus.cai),  64'(exp_cai));
            check("cmp_busy", 64'(bus.busy), 64'(m_run));
            check("cmp_done", 64'(bus.done), 64'(m_done));
            check("cmp_ovf",  64'(bus.ovf),  64'(m_ovf));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; bit c of each mask is the output seen in cycle c after the START edge.
    task automatic scn(input bit md, input int dv, input int bw, input bit soc, input bit with_stop,
                       input int n, input int stop_c, input int cao_c, input int restart_c,
                       output logic [63:0] cm, output logic [63:0] bm,
                       output logic [63:0] dm, output logic [63:0] om);
        cm = '0; bm = '0; dm = '0; om = '0;
        bus.mode        = md;
        bus.div         = dv[7:0];
        bus.burst       = bw[7:0];
        bus.stop_on_cao = soc;
        bus.start       = 1'b1;
        bus.stop        = with_stop;
        bus.cao_in      = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cm[c] = bus.cai;
            bm[c] = bus.busy;
            dm[c] = bus.done;
            om[c] = bus.ovf;
            bus.start = (c == restart_c);
            if (c == restart_c) bus.div = 8'd1;
            bus.stop   = (c == stop_c);
            bus.cao_in = (c == cao_c);
        end
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cao_in = 1'b0;
    endtask

    logic [63:0] cm, bm, dm, om;

    initial begin
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        cdn      = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.div = '0;
        bus.burst = '0; bus.stop_on_cao = 1'b0; bus.cao_in = 1'b0;

        #3;
        check("rst_cai",  64'(bus.cai),  64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ovf",  64'(bus.ovf),  64'd0);
        @(negedge clk);
        cdn    = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        scn(1'b0, 4, 0, 1'b0, 1'b0, 16, 14, 0, 0, cm, bm, dm, om);
        check("free4_cai",  cm, 64'h1110);
        check("free4_busy", bm, 64'h7FFE);
        check("free4_done", dm, 64'h8000);
        idle(3);

        scn(1'b1, 1, 5, 1'b0, 1'b0, 8, 0, 0, 0, cm, bm, dm, om);
        check("burst5_cai",  cm, 64'h3E);
        check("burst5_busy", bm, 64'h3E);
        check("burst5_done", dm, 64'h40);
        idle(3);

        scn(1'b1, 0, 5, 1'b0, 1'b0, 8, 0, 0, 0, cm, bm, dm, om);
        check("div0_cai",  cm, 64'h3E);
        check("div0_done", dm, 64'h40);
        idle(3);

        scn(1'b1, 3, 0, 1'b0, 1'b0, 3, 0, 0, 0, cm, bm, dm, om);
        check("burst0_cai",  cm, 64'h0);
        check("burst0_busy", bm, 64'h0);
        check("burst0_done", dm, 64'h2);
        idle(3);

        scn(1'b0, 2, 0, 1'b1, 1'b0, 8, 0, 6, 0, cm, bm, dm, om);
        check("soc1_cai",  cm, 64'h54);
        check("soc1_busy", bm, 64'h7E);
        check("soc1_done", dm, 64'h80);
        check("soc1_ovf",  om, 64'h0);
        idle(3);

        scn(1'b0, 2, 0, 1'b0, 1'b0, 9, 8, 6, 0, cm, bm, dm, om);
        check("soc0_cai",  cm, 64'h154);
        check("soc0_busy", bm, 64'h1FE);
        check("soc0_done", dm, 64'h200);
        check("soc0_ovf",  om, 64'h380);
        idle(3);

        scn(1'b0, 3, 0, 1'b0, 1'b0, 10, 9, 0, 2, cm, bm, dm, om);
        check("restart_cai",  cm, 64'h248);
        check("restart_busy", bm, 64'h3FE);
        check("restart_done", dm, 64'h400);
        check("restart_ovf",  om, 64'h0);
        idle(3);

        scn(1'b0, 2, 0, 1'b0, 1'b1, 4, 0, 0, 0, cm, bm, dm, om);
        check("ststop_cai",  cm, 64'h0);
        check("ststop_busy", bm, 64'h0);
        check("ststop_done", dm, 64'h0);
        idle(3);

        // Reset in the middle of a burst, between clock edges.
        bus.mode = 1'b1; bus.div = 8'd2; bus.burst = 8'd10; bus.stop_on_cao = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("rstmid_cai2", 64'(bus.cai), 64'd1);
        bus.cao_in = 1'b1;
        @(negedge clk);
        bus.cao_in = 1'b0;
        check("rstmid_ovf", 64'(bus.ovf), 64'd1);
        @(negedge clk);
        check("rstmid_cai4", 64'(bus.cai), 64'd1);
        #2 cdn = 1'b0;
        #1;
        check("rstmid_cai0",  64'(bus.cai),  64'd0);
        check("rstmid_busy0", 64'(bus.busy), 64'd0);
        check("rstmid_ovf0",  64'(bus.ovf),  64'd0);
        check("rstmid_done0", 64'(bus.done), 64'd0);
        @(negedge clk);
        cdn = 1'b1;
        @(negedge clk);
        check("rstpost_done", 64'(bus.done), 64'd0);
        check("rstpost_busy", 64'(bus.busy), 64'd0);

        scn(1'b0, 4, 0, 1'b0, 1'b0, 16, 14, 0, 0, cm, bm, dm, om);
        check("again_cai",  cm, 64'h1110);
        check("again_busy", bm, 64'h7FFE);
        check("again_done", dm, 64'h8000);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.stop        = ($urandom_range(0, 31) == 0);
            bus.mode        = 1'($urandom_range(0, 1));
            bus.div         = 8'($urandom_range(0, 5));
            bus.burst       = 8'($urandom_range(0, 6));
            bus.stop_on_cao = 1'($urandom_range(0, 1));
            bus.cao_in      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 cdn = 1'b0;
                #2 cdn = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0; bus.cao_in = 1'b0;
        idle(2);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
